wb_port_arbiter: RTL
====================

# wb_port_arbiter

Shares the single register-file write port between two writeback sources. The immediate-result path covers ALU, LUI, immediate ops and JAL link. The load path carries dbus data returning for LW. The block sits between the writeback stage and the register file. Load writes always win the port. Colliding immediate-result writes are parked in a small in-order buffer and drained on free cycles. Upstream is stalled only when that buffer is full.

## Interface
Parameters:
- DEPTH, 2, immediate-result buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- alu_valid  in  1  immediate-result write request
- alu_dst  in  regid_t  destination register
- alu_data  in  word_t  value to write
- alu_ready  out  1  request accepted this cycle when alu_valid && alu_ready
- ld_valid  in  1  load write request; cannot be back-pressured
- ld_dst  in  regid_t  load destination
- ld_data  in  word_t  load data (registered dbus data)
- rf_we  out  1  register-file write enable
- rf_wa  out  regid_t  write address
- rf_wd  out  word_t  write data
- q_reg  in  regid_t  forwarding query register
- q_hit  out  1  q_reg has a pending buffered write
- q_data  out  word_t  youngest pending value for q_reg
- busy  out  1  buffer non-empty

## Operation
- A request with destination 0 is a null write. It is accepted, never enqueued and never drives rf_we. A null load does not occupy the port.
- The port is granted once per cycle, in this priority order:
  - a live load (ld_valid && ld_dst!=0);
  - else the buffer head, if the buffer is non-empty;
  - else a new immediate-result request, which bypasses the buffer.
- An accepted, non-null immediate-result request is enqueued when it does not get the port. This happens when a live load is present or the buffer is non-empty.
- alu_ready = (count < DEPTH). There is no same-cycle drain credit.
- Ordering contract: a load arriving in a given cycle is younger than every entry already buffered.
  - On a live load, every buffered entry whose dst equals ld_dst is invalidated: its valid bit clears and it is skipped on drain.
  - An immediate-result request enqueued in the same cycle is younger than the load. It is not invalidated.
- Drain skips invalid entries in zero extra cycles. Each pop removes the head, whether valid or invalid; at most one pop per cycle. An invalid head may be popped in the same cycle a load takes the port.
- Forwarding: q_hit/q_data is a combinational search of valid buffer entries. The youngest match wins. q_reg==0 always gives q_hit=0.

## Timing
- rf_we/rf_wa/rf_wd are registered. A write granted in cycle N appears on the outputs in cycle N+1 for exactly one cycle.
- Reset values:
  - rf_we=0, rf_wa=0, rf_wd=0;
  - all entries invalid, count=0;
  - alu_ready=1, busy=0, q_hit=0, q_data=0.
- alu_ready, busy, q_hit and q_data depend only on registered state and q_reg. There is no combinational path from alu_valid or ld_valid.
- Buffer full with a load present: alu_ready stays 0 until a pop occurs. Loads are never blocked.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Reset asserted mid-operation: all pending buffered writes are discarded and rf_we drops immediately (asynchronous).

## Configuration
- WB_ARB_FWD_EN defined: forwarding search is present as described.
- WB_ARB_FWD_EN undefined:
  - search logic is removed and q_hit/q_data are tied 0;
  - q_reg is an unused input;
  - the port list is unchanged.

## Structure
- regid_t and word_t come from the shared defs package.
- A new wb_entry_t {valid, dst, data} is added to the same package.
- One sub-module: wb_fifo (circular buffer with per-entry invalidate-by-dst and a head-skip pop). The arbiter wraps wb_fifo with grant logic and output registers.

## Test plan
- Idle bypass:
  - stimulus: alu_valid, dst=5, data=0x11 in cycle 0, nothing else;
  - response: rf_we=1, wa=5, wd=0x11 in cycle 1; busy stays 0.
- Collision:
  - stimulus: cycle 0, ld (dst=3, 0xAA) plus alu (dst=4, 0xBB);
  - response: cycle 1 writes r3=0xAA; cycle 2 writes r4=0xBB; busy=1 during cycle 1 only.
- Full stall (DEPTH=2):
  - stimulus: loads to r1/r2/r3 in cycles 0–2, alu requests to r6/r7/r8 in cycles 0–2;
  - response: alu_ready=0 in cycle 2; r8 is accepted only after the first drain; final write order r1,r2,r3,r6,r7,r8.
- Invalidate:
  - stimulus: buffer holds r9=0x1; load to r9=0x2 arrives;
  - response: r9 is written 0x2 only; the stale 0x1 entry is skipped and never reaches rf_we.
- Null writes:
  - stimulus: alu dst=0 with buffer full; load dst=0;
  - response: alu dst=0 is still not accepted (alu_ready=0 when full); load dst=0 gives rf_we=0 and lets the head drain that cycle.
- Forwarding (WB_ARB_FWD_EN):
  - stimulus: buffer holds r4=0x10 then r4=0x20; q_reg=4;
  - response: q_hit=1, q_data=0x20; with the macro undefined, q_hit=0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback definitions: register id, data word and the buffered-write entry.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned XLEN  = 32;

    typedef logic [REG_W-1:0] regid_t;
    typedef logic [XLEN-1:0]  word_t;

    typedef struct packed {
        logic   valid;
        regid_t dst;
        word_t  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: immediate-result and load requests, register-file write, forwarding query.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic   alu_valid;
    regid_t alu_dst;
    word_t  alu_data;
    logic   alu_ready;
    logic   ld_valid;
    regid_t ld_dst;
    word_t  ld_data;
    logic   rf_we;
    regid_t rf_wa;
    word_t  rf_wd;
    regid_t q_reg;
    logic   q_hit;
    word_t  q_data;
    logic   busy;

    modport master (
        output alu_valid, alu_dst, alu_data, ld_valid, ld_dst, ld_data, q_reg,
        input  alu_ready, rf_we, rf_wa, rf_wd, q_hit, q_data, busy
    );

    modport slave (
        input  alu_valid, alu_dst, alu_data, ld_valid, ld_dst, ld_data, q_reg,
        output alu_ready, rf_we, rf_wa, rf_wd, q_hit, q_data, busy
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order buffer of parked immediate-result writes with invalidate-by-dst and head pop.
// Forwarding search is built only when WB_ARB_FWD_EN is defined.
module wb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  regid_t                   i_push_dst,
    input  word_t                    i_push_data,
    input  logic                     i_pop,
    input  logic                     i_inval,
    input  regid_t                   i_inval_dst,
    input  regid_t                   i_q_reg,
    output wb_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_q_hit,
    output word_t                    o_q_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    // Invalidate older entries first; a same-cycle push lands afterwards and stays valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_inval) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (r_mem[i].dst == i_inval_dst) r_mem[i].valid <= 1'b0;
                end
            end
            if (i_push) begin
                r_mem[r_wr_ptr] <= '{valid: 1'b1, dst: i_push_dst, data: i_push_data};
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

`ifdef WB_ARB_FWD_EN
    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        o_q_hit  = 1'b0;
        o_q_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (i_q_reg != '0)
                && r_mem[r_rd_ptr + PW'(i)].valid
                && (r_mem[r_rd_ptr + PW'(i)].dst == i_q_reg)) begin
                o_q_hit  = 1'b1;
                o_q_data = r_mem[r_rd_ptr + PW'(i)].data;
            end
        end
    end
`else
    logic w_unused_q;
    assign w_unused_q = ^i_q_reg;
    assign o_q_hit    = 1'b0;
    assign o_q_data   = '0;
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: loads win, colliding immediate results park in wb_fifo.
// Define WB_ARB_FWD_EN to enable the forwarding search on q_reg.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               resetn,
    wb_port_arbiter_if.slave   bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          w_live_ld;
    logic          w_empty;
    logic          w_alu_live;
    logic          w_push;
    logic          w_pop;
    wb_entry_t     w_head;
    logic [CW-1:0] w_count;
    logic          w_we;
    regid_t        w_wa;
    word_t         w_wd;

    logic          r_rf_we;
    regid_t        r_rf_wa;
    word_t         r_rf_wd;

    assign w_empty       = (w_count == '0);
    assign bus.alu_ready = (w_count < CW'(DEPTH));
    assign bus.busy      = !w_empty;

    assign w_live_ld  = bus.ld_valid && (bus.ld_dst != '0);
    assign w_alu_live = bus.alu_valid && bus.alu_ready && (bus.alu_dst != '0);
    assign w_push     = w_alu_live && (w_live_ld || !w_empty);
    // An invalid head is discarded any cycle; a valid head only when no load holds the port.
    assign w_pop      = !w_empty && (!w_head.valid || !w_live_ld);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_push_dst  (bus.alu_dst),
        .i_push_data (bus.alu_data),
        .i_pop       (w_pop),
        .i_inval     (w_live_ld),
        .i_inval_dst (bus.ld_dst),
        .i_q_reg     (bus.q_reg),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_q_hit     (bus.q_hit),
        .o_q_data    (bus.q_data)
    );

    // Port grant: live load, then valid buffer head, then bypassing immediate result.
    always_comb begin
        w_we = 1'b0;
        w_wa = r_rf_wa;
        w_wd = r_rf_wd;
        if (w_live_ld) begin
            w_we = 1'b1;
            w_wa = bus.ld_dst;
            w_wd = bus.ld_data;
        end else if (!w_empty && w_head.valid) begin
            w_we = 1'b1;
            w_wa = w_head.dst;
            w_wd = w_head.data;
        end else if (w_empty && w_alu_live) begin
            w_we = 1'b1;
            w_wa = bus.alu_dst;
            w_wd = bus.alu_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rf_we <= 1'b0;
            r_rf_wa <= '0;
            r_rf_wd <= '0;
        end else begin
            r_rf_we <= w_we;
            r_rf_wa <= w_wa;
            r_rf_wd <= w_wd;
        end
    end

    assign bus.rf_we = r_rf_we;
    assign bus.rf_wa = r_rf_wa;
    assign bus.rf_wd = r_rf_wd;

endmodule
